// File: rtl/conv_stream_pkg.sv
// ---------------------------------------------------------------------------
// conv_stream_pkg
// Shared definitions for the conv pixel streamer:
//   - stream_state_e : streamer FSM states (IDLE, PRIME, STREAM, DONE)
//   - addr_width()   : address/counter width helper, never returns 0 so that
//                      degenerate sizes (e.g. a single channel) still give a
//                      legal one-bit vector.
// ---------------------------------------------------------------------------
package conv_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_e;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_ram.sv
// ---------------------------------------------------------------------------
// pixel_frame_ram
// Single-port synchronous frame buffer with a registered read (1-cycle
// latency). Read-before-write on a shared address port. rdata only updates
// on cycles with en=1, so holding en low keeps the last read word stable.
// Contents are not reset.
// Ports:
//   clk    - clock, rising edge
//   en     - port enable (read and/or write this cycle)
//   we     - write enable, qualified by en
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data
// ---------------------------------------------------------------------------
module pixel_frame_ram #(
  parameter int DEPTH  = 48,
  parameter int DATA_W = 8,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/conv_pixel_streamer.sv
// ---------------------------------------------------------------------------
// conv_pixel_streamer
// Holds one CIN x H x W frame in block RAM and streams it to a downstream
// conv2d engine with a valid/ready handshake, raster order with channels
// interleaved (y outer, x, c inner).
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data - frame-buffer load port, honoured only while idle
//   start      - request one frame transmission (ignored while busy)
//   ready_in   - downstream can accept a sample
//   pixel_out/valid_out/last_out - output stream (last_out marks final sample)
//   busy       - streamer is not idle
//   done       - one-cycle pulse after the final transfer
//   wr_err     - one-cycle pulse when a write is rejected
// Datapath: fetch counters -> RAM output register (prefetch stage, tracked
// by q_valid_reg) -> output register. The prefetch stage refills in the same
// cycle the output register drains, giving one transfer per cycle with
// ready_in high; on a stall the RAM enable is dropped so its output holds.
// ---------------------------------------------------------------------------
module conv_pixel_streamer
  import conv_stream_pkg::*;
#(
  parameter  int CIN    = 3,
  parameter  int H      = 64,
  parameter  int W      = 64,
  parameter  int DATA_W = 8,
  localparam int DEPTH  = CIN * H * W,
  localparam int AW     = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              ready_in,
  output logic [DATA_W-1:0] pixel_out,
  output logic              valid_out,
  output logic              last_out,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  localparam int CW = addr_width(CIN);
  localparam int XW = addr_width(W);
  localparam int YW = addr_width(H);

  localparam logic [CW-1:0] C_MAX     = CW'(CIN - 1);
  localparam logic [XW-1:0] X_MAX     = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX     = YW'(H - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  stream_state_e state_reg;

  // Fetch position of the next sample to read from the RAM
  logic [CW-1:0] c_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;
  logic          fetch_done_reg;

  // Prefetch stage: RAM output register holds a live sample when set
  logic          q_valid_reg;
  logic          q_last_reg;

  logic              in_range;
  logic              write_ok;
  logic              streaming;
  logic              out_load;
  logic              fetch_step;
  logic              fetch_is_last;
  logic              xfer_last;
  logic [AW-1:0]     fetch_addr;
  logic              ram_en;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    in_range      = ({1'b0, wr_addr} < DEPTH_EXT);
    write_ok      = (state_reg == ST_IDLE) && wr_en && in_range;
    streaming     = (state_reg == ST_STREAM);
    // Output register takes the prefetched sample when empty or draining
    out_load      = streaming && q_valid_reg && (!valid_out || ready_in);
    // Prefetch stage refills when empty or being consumed this cycle
    fetch_step    = ((state_reg == ST_PRIME) || streaming) &&
                    (!q_valid_reg || out_load);
    fetch_is_last = (c_reg == C_MAX) && (x_reg == X_MAX) && (y_reg == Y_MAX);
    xfer_last     = streaming && valid_out && ready_in && last_out;
    fetch_addr    = AW'((int'(y_reg) * W + int'(x_reg)) * CIN + int'(c_reg));
    // Single port: writes only happen in IDLE, reads only while streaming
    ram_en        = write_ok || (fetch_step && !fetch_done_reg);
    ram_we        = write_ok;
    ram_addr      = write_ok ? wr_addr : fetch_addr;
  end

  pixel_frame_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      c_reg          <= '0;
      x_reg          <= '0;
      y_reg          <= '0;
      fetch_done_reg <= 1'b0;
      q_valid_reg    <= 1'b0;
      q_last_reg     <= 1'b0;
      pixel_out      <= '0;
      valid_out      <= 1'b0;
      last_out       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && !write_ok;

      // Output register
      if (out_load) begin
        pixel_out <= ram_rdata;
        valid_out <= 1'b1;
        last_out  <= q_last_reg;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
        last_out  <= 1'b0;
      end

      // Prefetch stage and fetch counters (c wraps into x, x into y)
      if (fetch_step) begin
        q_valid_reg <= !fetch_done_reg;
        q_last_reg  <= !fetch_done_reg && fetch_is_last;
        if (!fetch_done_reg) begin
          if (fetch_is_last) begin
            fetch_done_reg <= 1'b1;
          end else if (c_reg == C_MAX) begin
            c_reg <= '0;
            if (x_reg == X_MAX) begin
              x_reg <= '0;
              y_reg <= y_reg + 1'b1;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
          end else begin
            c_reg <= c_reg + 1'b1;
          end
        end
      end

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg      <= ST_PRIME;
            busy           <= 1'b1;
            c_reg          <= '0;
            x_reg          <= '0;
            y_reg          <= '0;
            fetch_done_reg <= 1'b0;
            q_valid_reg    <= 1'b0;
            q_last_reg     <= 1'b0;
          end
        end
        ST_PRIME: begin
          state_reg <= ST_STREAM;
        end
        ST_STREAM: begin
          if (xfer_last) begin
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/conv_pixel_streamer.md
CONV_PIXEL_STREAMER -- requirements
Module: conv_pixel_streamer

Interface
REQ-001 Parameter CIN, default 3, input channels per pixel position.
REQ-002 Parameter H, default 64, frame height in rows.
REQ-003 Parameter W, default 64, frame width in columns.
REQ-004 Parameter DATA_W, default 8, pixel sample width in bits.
REQ-005 Port list SHALL be exactly as follows; clk and rst come first.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  frame-buffer write strobe.
- wr_addr  input  AW  write address; AW = clog2(CIN*H*W).
- wr_data  input  DATA_W  write sample.
- start  input  1  request one frame transmission.
- ready_in  input  1  downstream conv2d can accept a sample.
- pixel_out  output  DATA_W  streamed sample.
- valid_out  output  1  pixel_out is valid.
- last_out  output  1  final sample of frame, qualified by valid_out.
- busy  output  1  streamer not IDLE.
- done  output  1  one-cycle pulse after last transfer.
- wr_err  output  1  one-cycle pulse when a write is rejected.

Function
REQ-006 Frame buffer SHALL hold CIN*H*W samples; address = (y*W + x)*CIN + c.
REQ-007 Emission order SHALL be raster, channel-interleaved: y outer, then x, then c inner.
REQ-008 Writes SHALL land only in IDLE; wr_en outside IDLE is dropped and wr_err pulses next cycle.
REQ-009 Out-of-range wr_addr (>= CIN*H*W) SHALL be dropped with a wr_err pulse.
REQ-010 FSM states SHALL be IDLE, PRIME, STREAM, DONE.
- IDLE -> PRIME when start=1.
- PRIME -> STREAM after one cycle (RAM read latency).
- STREAM -> DONE on transfer of the last sample.
- DONE -> IDLE after one cycle.
REQ-011 start outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-012 Transfer SHALL occur on an edge with valid_out=1 and ready_in=1.
REQ-013 While valid_out=1 and ready_in=0, pixel_out, last_out and valid_out SHALL hold stable.
REQ-014 valid_out SHALL first rise two edges after the edge sampling start.
REQ-015 With ready_in held high, one transfer per cycle SHALL be sustained with no bubbles; a prefetch/skid register is required.
REQ-016 last_out SHALL be 1 only with the sample at y=H-1, x=W-1, c=CIN-1.
REQ-017 done SHALL be high for exactly the cycle after the last transfer; valid_out is 0 in that cycle.
REQ-018 busy SHALL be 1 in PRIME, STREAM and DONE, and 0 in IDLE.
REQ-019 Exactly CIN*H*W transfers SHALL occur per start; counters SHALL wrap c->x->y without skipping or repeating.
REQ-020 The buffer SHALL retain contents across frames; repeated start re-sends identical data.

Reset
REQ-021 rst SHALL force IDLE and clear all counters.
REQ-022 rst SHALL zero pixel_out, valid_out, last_out, busy, done and wr_err.
REQ-023 rst mid-frame SHALL drop valid_out at the next edge, with no done pulse.
REQ-024 rst need not clear buffer contents.

Structure
REQ-025 Package conv_stream_pkg SHALL hold the state enum and an address-width helper function.
REQ-026 Sub-module pixel_frame_ram SHALL implement the buffer: single-port, synchronous, registered read, 1-cycle latency.

Verification (bench parameters CIN=3, H=W=4, DATA_W=8)
REQ-027 Write buffer[i]=i for i=0..47, start, ready_in=1 -> 48 consecutive samples 0..47; last_out with 47; done next cycle.
REQ-028 Toggle ready_in 1,0 every cycle -> same 0..47 sequence; pixel_out stable during every stall; 48 transfers total.
REQ-029 wr_en at address 5 during STREAM -> wr_err pulse; repeat frame still shows 5 at index 5.
REQ-030 wr_addr=48 in IDLE -> wr_err pulse; no buffer change.
REQ-031 Second start during STREAM -> ignored; exactly one done and 48 transfers.
REQ-032 rst at transfer 20 -> valid_out=0 next cycle, busy=0, no done; new start replays samples 0..47.
